uop_buf_ctrl: RTL

Owns the single-port uop buffer RAM and shares it between two requesters: the fill side (trace builder writing uop lines) and the fetch side (uop fetch stage reading lines).
Tracks write/read pointers and occupancy, arbitrates the RAM port each cycle, and delivers read data to fetch with a valid strobe.
Sits between the uop buffer RAM macro and uop fetch; flushed by the pipeline clear.

---
 rtl/uop_pkg.sv | 23 ++
 rtl/uop_buf_ctrl_if.sv | 36 +++
 rtl/uop_buf_arb.sv | 49 ++++
 rtl/uop_buf_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/uop_pkg.sv
// Shared types and sizing for the uop buffer: default geometry, line layout and controller FSM states.
// Optional perf counters in uop_buf_ctrl are enabled with the macro UOP_BUF_CTRL_PERF_EN.
package uop_pkg;

  localparam int UOP_BUF_SIZE           = 64;
  localparam int UOP_BUF_WIDTH          = 72;
  localparam int MAX_PREDICT_DEPTH_BITS = 4;
  localparam int STARVE_LIMIT           = 4;

  // One buffer line: two instructions plus one branch tag per instruction.
  typedef struct packed {
    logic [31:0]                       instr_1;
    logic [31:0]                       instr_2;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] tag_1;
    logic [MAX_PREDICT_DEPTH_BITS-1:0] tag_2;
  } uop_line_t;

  typedef enum logic {
    IDLE = 1'b0,
    RD   = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/uop_buf_ctrl_if.sv
// Fill, fetch and RAM-port signals of the uop buffer controller.
// The slave modport is the controller; the master modport is its surroundings.
interface uop_buf_ctrl_if #(
  parameter int WIDTH = uop_pkg::UOP_BUF_WIDTH,
  parameter int SIZE  = uop_pkg::UOP_BUF_SIZE
);
  localparam int AW = $clog2(SIZE);

  logic             fill_valid;
  logic [WIDTH-1:0] fill_data;
  logic             fill_ready;
  logic             fetch_req;
  logic             fetch_valid;
  logic [WIDTH-1:0] fetch_data;
  logic             ram_en;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;
  logic [AW:0]      count;
  logic             full;
  logic             empty;

  modport master (
    output fill_valid, fill_data, fetch_req, ram_rdata,
    input  fill_ready, fetch_valid, fetch_data, ram_en, ram_we, ram_addr,
           ram_wdata, count, full, empty
  );

  modport slave (
    input  fill_valid, fill_data, fetch_req, ram_rdata,
    output fill_ready, fetch_valid, fetch_data, ram_en, ram_we, ram_addr,
           ram_wdata, count, full, empty
  );

endinterface

// File: rtl/uop_buf_arb.sv
// RAM port arbiter: read normally wins, but a fill that has lost STARVE_LIMIT
// consecutive cycles to fetch gets the next one.
module uop_buf_arb #(
  parameter int STARVE_LIMIT = uop_pkg::STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic rd_req,
  input  logic wr_req,
  output logic rd_gnt,
  output logic wr_gnt
);
  import uop_pkg::*;

  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;
  logic       starved;

  assign starved = (starve_cnt_reg == 4'(STARVE_LIMIT));

  // Reset is folded in so the RAM port stays quiet while reset is held.
  always_comb begin
    wr_gnt = 1'b0;
    rd_gnt = 1'b0;
    if (!reset && !clear) begin
      wr_gnt = wr_req && (!rd_req || starved);
      rd_gnt = rd_req && !wr_gnt;
    end
  end

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (clear || wr_gnt || !wr_req) begin
      starve_cnt_next = 4'd0;
    end else if (rd_gnt && !starved) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

endmodule

// File: rtl/uop_buf_ctrl.sv
// Uop buffer controller: shares the single-port uop RAM between fill and fetch,
// tracks pointers/occupancy, and strobes fetch_valid one cycle after each read.
// Define UOP_BUF_CTRL_PERF_EN to add the perf_fill_stall / perf_conflict counters.
module uop_buf_ctrl #(
  parameter int UOP_BUF_SIZE  = uop_pkg::UOP_BUF_SIZE,
  parameter int UOP_BUF_WIDTH = uop_pkg::UOP_BUF_WIDTH,
  parameter int STARVE_LIMIT  = uop_pkg::STARVE_LIMIT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
`ifdef UOP_BUF_CTRL_PERF_EN
  output logic [31:0]    perf_fill_stall,
  output logic [31:0]    perf_conflict,
`endif
  uop_buf_ctrl_if.slave  bus
);
  import uop_pkg::*;

  localparam int AW = $clog2(UOP_BUF_SIZE);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  ctrl_state_t   state_reg;
  ctrl_state_t   state_next;

  logic full_int;
  logic empty_int;
  logic rd_req;
  logic wr_req;
  logic rd_gnt;
  logic wr_gnt;

  assign full_int  = (count_reg == CW'(UOP_BUF_SIZE));
  assign empty_int = (count_reg == '0);
  assign rd_req    = bus.fetch_req && !empty_int;
  assign wr_req    = bus.fill_valid && !full_int;

  uop_buf_arb #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .rd_req (rd_req),
    .wr_req (wr_req),
    .rd_gnt (rd_gnt),
    .wr_gnt (wr_gnt)
  );

  // Grants are mutually exclusive, so count moves by at most one per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_gnt) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        count_reg  <= count_reg + 1'b1;
      end else if (rd_gnt) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        count_reg  <= count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (!clear && rd_gnt) begin
      state_next = RD;
    end
  end

  assign bus.ram_en      = rd_gnt || wr_gnt;
  assign bus.ram_we      = wr_gnt;
  assign bus.ram_addr    = wr_gnt ? wr_ptr_reg : rd_ptr_reg;
  assign bus.ram_wdata   = bus.fill_data;
  assign bus.fill_ready  = wr_gnt;
  assign bus.fetch_valid = (state_reg == RD);
  assign bus.fetch_data  = bus.ram_rdata;
  assign bus.count       = count_reg;
  assign bus.full        = full_int;
  assign bus.empty       = empty_int;

`ifdef UOP_BUF_CTRL_PERF_EN
  logic [1:0] perf_inc;
  assign perf_inc = {rd_req && wr_req, bus.fill_valid && !wr_gnt};

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    logic [31:0] cnt_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (clear) begin
        cnt_reg <= '0;
      end else if (perf_inc[gi] && (cnt_reg != 32'hFFFF_FFFF)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign perf_fill_stall = g_perf[0].cnt_reg;
  assign perf_conflict   = g_perf[1].cnt_reg;
`endif

endmodule
